// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase controller.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    StWaitLock,
    StIdle,
    StSetup,
    StStepLo,
    StStepHi,
    StLoad,
    StDone
  } state_e;

  typedef logic [1:0] phase_sel_t;

  localparam phase_sel_t SEL_CLKOS  = 2'b00;
  localparam phase_sel_t SEL_CLKOS2 = 2'b01;
  localparam phase_sel_t SEL_CLKOS3 = 2'b10;
  localparam phase_sel_t SEL_CLKOP  = 2'b11;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Phase-shift request channel between a requester and the PLL phase controller.
interface pll_phase_ctrl_if
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = 8
);
  logic              req_valid;
  logic              req_ready;
  phase_sel_t        req_sel;
  logic              req_dir;
  logic [STEP_W-1:0] req_steps;
  logic              done;
  logic              err;
  logic              busy;

  modport master (
    output req_valid, req_sel, req_dir, req_steps,
    input  req_ready, done, err, busy
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_steps,
    output req_ready, done, err, busy
  );
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end
endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences EHXPLLL dynamic phase steps behind a debounced lock, one request at a time.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned PULSE_CYC   = 2,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned STEP_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pll_locked,
  pll_phase_ctrl_if.slave req,
  output logic            stable,
  output phase_sel_t      phasesel,
  output logic            phasedir,
  output logic            phasestep,
  output logic            phaseloadreg
);
  localparam int unsigned LockW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TmrW  = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);

  logic lk;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  logic [LockW-1:0]  lock_cnt_q, lock_cnt_d;
  logic              stable_q;
  state_e            state_q, state_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  phase_sel_t        sel_q, sel_d;
  logic              dir_q, dir_d;
  logic              err_d;
  logic              ready_q, busy_q, done_q, err_q, step_q, load_q;

  // Saturating run-length of consecutive synchronised-locked cycles.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!lk) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LockW'(LOCK_STABLE)) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    steps_d = steps_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    case (state_q)
      StWaitLock: begin
        if (stable_q) state_d = StIdle;
      end
      StIdle: begin
        if (req.req_valid && ready_q) begin
          sel_d   = req.req_sel;
          dir_d   = req.req_dir;
          steps_d = req.req_steps;
          state_d = (req.req_steps == '0) ? StDone : StSetup;
        end else if (!stable_q) begin
          state_d = StWaitLock;
        end
      end
      StSetup: begin
        if (tmr_q == TmrW'(SETUP_CYC - 1)) state_d = StStepLo;
        else tmr_d = tmr_q + 1'b1;
      end
      StStepLo: begin
        if (tmr_q == TmrW'(PULSE_CYC - 1)) state_d = StStepHi;
        else tmr_d = tmr_q + 1'b1;
      end
      StStepHi: begin
        if (tmr_q == TmrW'(GAP_CYC - 1)) begin
          steps_d = steps_q - 1'b1;
          state_d = (steps_q == STEP_W'(1)) ? StLoad : StStepLo;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StLoad: begin
        if (tmr_q == TmrW'(PULSE_CYC - 1)) state_d = StDone;
        else tmr_d = tmr_q + 1'b1;
      end
      StDone: begin
        state_d = stable_q ? StIdle : StWaitLock;
      end
      default: state_d = StWaitLock;
    endcase

    // Lock loss while touching the PLL overrides any timed transition.
    if (!stable_q && (state_q inside {StSetup, StStepLo, StStepHi, StLoad})) begin
      state_d = StWaitLock;
      tmr_d   = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt_q <= '0;
      stable_q   <= 1'b0;
      state_q    <= StWaitLock;
      tmr_q      <= '0;
      steps_q    <= '0;
      sel_q      <= SEL_CLKOS;
      dir_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      step_q     <= 1'b1;
      load_q     <= 1'b1;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      stable_q   <= (lock_cnt_d == LockW'(LOCK_STABLE));
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      steps_q    <= steps_d;
      sel_q      <= sel_d;
      dir_q      <= dir_d;
      ready_q    <= (state_d == StIdle);
      busy_q     <= (state_d inside {StSetup, StStepLo, StStepHi, StLoad, StDone});
      done_q     <= (state_d == StDone);
      err_q      <= err_d;
      step_q     <= (state_d != StStepLo);
      load_q     <= (state_d != StLoad);
    end
  end

  assign req.req_ready = ready_q;
  assign req.busy      = busy_q;
  assign req.done      = done_q;
  assign req.err       = err_q;
  assign stable        = stable_q;
  assign phasesel      = sel_q;
  assign phasedir      = dir_q;
  assign phasestep     = step_q;
  assign phaseloadreg  = load_q;

endmodule
